if_prefetch_unit: RTL
=====================

Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It replaces the single-register IF stage with:
- an autonomous PC sequencer;
- a variable-latency instruction-memory request/acknowledge interface;
- a DEPTH-entry prefetch queue feeding ID through a valid/ready handshake.

Branch/jump redirects from MEM flush the queue and discard stale in-flight fetches.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width; PC increment = DATA_W/8
DEPTH, 4, prefetch queue entries; power of 2, >=2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  main clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect  in  1  branch/jump taken in MEM; flush and refetch
redirect_addr  in  ADDR_W  new fetch address
inst_ren  out  1  instruction read request
inst_addr  out  ADDR_W  request address; stable while inst_ren high and no inst_ack
inst_ack  in  1  memory response valid; may arrive in the same cycle as inst_ren
inst_data  in  DATA_W  fetched word, valid with inst_ack
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head (stall = 0)
id_inst  out  DATA_W  head instruction
id_pc  out  ADDR_W  head instruction address
id_pc_next  out  ADDR_W  id_pc + DATA_W/8
fifo_count  out  clog2(DEPTH+1)  occupied entries
busy  out  1  request outstanding (state != IDLE)

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, state=IDLE.
  - Queue empty: count=0, rd/wr pointers=0.
  - Outputs: id_valid=0, fifo_count=0, busy=0.
  - inst_ren is masked low while rst_n=0.
  - Reset mid-request: the in-flight request is abandoned. The memory side tolerates this; any late ack arriving after reset while in IDLE with inst_ren=0 is ignored.
- space = (count < DEPTH), using registered count. No pop credit: a full queue issues nothing in the cycle it is popped.
- inst_ren = (state==IDLE & space) | state==WAIT | state==WAIT_STALE.
- inst_addr = fetch_pc in IDLE/WAIT. In WAIT_STALE it is the latched address of the stale request.
- FSM, state IDLE:
  - ren & ack in the same cycle: push {fetch_pc, inst_data}, fetch_pc += DATA_W/8, stay IDLE. This gives back-to-back 1 instr/cycle.
  - ren & no ack: go to WAIT.
- FSM, state WAIT:
  - ack: push the entry, advance fetch_pc, go to IDLE.
  - redirect without ack: go to WAIT_STALE.
  - redirect with ack in the same cycle: the response is dropped, go to IDLE.
- FSM, state WAIT_STALE:
  - Keep the request asserted until ack.
  - On ack: drop the data, go to IDLE.
  - The new target is requested from the following cycle.
- Redirect (any state):
  - Queue is flushed: count=0, pointers reset.
  - fetch_pc = redirect_addr.
  - Redirect beats push, pop and ack in the same cycle. A pop in that cycle is void.
  - An IDLE same-cycle ren&ack is dropped, and fetch_pc takes redirect_addr.
  - Redirect while in WAIT_STALE: update fetch_pc only, stay in WAIT_STALE.
- Pop = id_valid & id_ready & ~redirect.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- id_valid = (count != 0).
  - id_inst/id_pc come from the head entry.
  - Data is stable while id_valid & ~id_ready.
- PC arithmetic wraps modulo 2^ADDR_W; 0xFFFFFFFC + 4 = 0. No alignment check.
- Latency: first inst_ren in the first cycle after rst_n deasserts. With zero-wait memory, id_valid rises one cycle after the accepted ack.

Test Plan:
1. Zero-wait memory (ack=ren), id_ready=1, RESET_PC=0 -> inst_addr 0,4,8,... on consecutive cycles; id_pc 0,4,8 one cycle later; fifo_count stays 1.
2. id_ready=0, zero-wait memory -> exactly 4 fetches (0..C); inst_ren falls with fifo_count=4. Then id_ready=1 for one cycle -> pops pc 0; next fetch 0x10 issued the following cycle.
3. Memory latency 3 cycles, redirect to 0x100 while request for 0x8 pending -> inst_addr holds 0x8 until ack; its data never appears on id_inst; next request is 0x100; queue empty after redirect.
4. Redirect coincident with ack in IDLE, and with pop of a full queue -> fifo_count=0 next cycle; the acked word and popped head are discarded; next inst_addr = redirect_addr.
5. RESET_PC=0xFFFFFFF8, zero-wait -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; id_pc_next of the second entry = 0x0.
6. rst_n pulsed low in WAIT with fifo_count=3 -> immediately id_valid=0, busy=0, fifo_count=0; after release, first request is RESET_PC.

Source files
------------

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: autonomous PC sequencer, req/ack instruction-memory port and a
// DEPTH-entry prefetch queue drained by ID through a valid/ready handshake.
module if_prefetch_unit #(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_addr_i,
  output logic                         inst_ren_o,
  output logic [ADDR_W-1:0]            inst_addr_o,
  input  logic                         inst_ack_i,
  input  logic [DATA_W-1:0]            inst_data_i,
  output logic                         id_valid_o,
  input  logic                         id_ready_i,
  output logic [DATA_W-1:0]            id_inst_o,
  output logic [ADDR_W-1:0]            id_pc_o,
  output logic [ADDR_W-1:0]            id_pc_next_o,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
  output logic                         busy_o
);

  localparam int unsigned       PtrW  = $clog2(DEPTH);
  localparam int unsigned       CntW  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {StIdle, StWait, StWaitStale} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   stale_addr_q, stale_addr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
  logic [DATA_W-1:0]   inst_mem_q [DEPTH];

  logic space;
  logic push;
  logic pop;

  assign space = (count_q < CntW'(DEPTH));
  // Responses to a request abandoned by a redirect are never queued.
  assign push  = inst_ren_o & inst_ack_i & ~redirect_i & (state_q != StWaitStale);
  assign pop   = id_valid_o & id_ready_i & ~redirect_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= inst_data_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A request redirected before its ack must still be completed, but as stale.
        if (inst_ren_o && !inst_ack_i) state_d = redirect_i ? StWaitStale : StWait;
      end
      StWait: begin
        if (inst_ack_i)      state_d = StIdle;
        else if (redirect_i) state_d = StWaitStale;
      end
      StWaitStale: begin
        if (inst_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (redirect_i)  fetch_pc_d = redirect_addr_i;
    else if (push)   fetch_pc_d = fetch_pc_q + PcInc;

    if ((state_q != StWaitStale) && inst_ren_o && !inst_ack_i && redirect_i) begin
      stale_addr_d = fetch_pc_q;
    end

    if (redirect_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Outputs
  always_comb begin
    busy_o       = (state_q != StIdle);
    inst_ren_o   = rst_ni & (((state_q == StIdle) & space) | (state_q != StIdle));
    inst_addr_o  = (state_q == StWaitStale) ? stale_addr_q : fetch_pc_q;
    id_valid_o   = (count_q != '0);
    id_inst_o    = inst_mem_q[rd_ptr_q];
    id_pc_o      = pc_mem_q[rd_ptr_q];
    id_pc_next_o = pc_mem_q[rd_ptr_q] + PcInc;
    fifo_count_o = count_q;
  end

endmodule
